// File: rtl/aes_inv_keysched.sv
// AES-128 round-key sequencer: streams RK0..RK10 or RK10..RK0
// over a valid/ready port, one round key per handshake.
module aes_inv_keysched #(
    parameter int VLEN = 128,
    parameter int NR   = 10
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            dir,
    input  logic [VLEN-1:0] key_in,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [VLEN-1:0] rk_data,
    output logic [3:0]      rk_round,
    output logic            rk_last,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t          state, next;
    logic [VLEN-1:0] key;
    logic [3:0]      cnt;
    logic            dir_q;
    logic            armed;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] i1, i2, i3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] sb_in, rot, t;
    logic [3:0]  rc_idx;
    logic        use_inv;
    logic        last_hit;
    logic [VLEN-1:0] step_key;

    assign w0 = key[31:0];
    assign w1 = key[63:32];
    assign w2 = key[95:64];
    assign w3 = key[127:96];

    // Inverse step needs w3^w2 before the S-box; forward step uses w3
    assign use_inv = (state == STREAM) && dir_q;
    assign i3      = w3 ^ w2;
    assign i2      = w2 ^ w1;
    assign i1      = w1 ^ w0;
    assign sb_in   = use_inv ? i3 : w3;
    assign rc_idx  = use_inv ? cnt : cnt + 4'd1;
    assign rot     = {sb_in[7:0], sb_in[31:8]};
    assign t       = {sbox(rot[31:24]), sbox(rot[23:16]),
                      sbox(rot[15:8]), sbox(rot[7:0])}
                     ^ {24'h0, rcon(rc_idx)};

    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign step_key = use_inv ? {i3, i2, i1, w0 ^ t}
                              : {f3, f2, f1, f0};

    assign last_hit = dir_q ? (cnt == 4'd0) : (cnt == LAST);

    assign rk_valid = (state == STREAM);
    assign rk_data  = rk_valid ? key : '0;
    assign rk_round = rk_valid ? cnt : 4'd0;
    assign rk_last  = rk_valid && last_hit;
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= next;
    end

    // Next-state decode
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start && armed) next = dir ? EXPAND : STREAM;
            EXPAND:  if (cnt == LAST - 4'd1) next = STREAM;
            STREAM:  if (rk_ready && last_hit) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Key register, round counter and captured direction
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key   <= '0;
            cnt   <= 4'd0;
            dir_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && armed) begin
                        key   <= key_in;
                        cnt   <= 4'd0;
                        dir_q <= dir;
                    end
                end
                EXPAND: begin
                    key <= step_key;
                    cnt <= cnt + 4'd1;
                end
                STREAM: begin
                    if (rk_ready && !last_hit) begin
                        key <= step_key;
                        cnt <= dir_q ? cnt - 4'd1 : cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
